// File: rtl/uart_hdlc_deframer.sv
// ---------------------------------------------------------------------------
// uart_hdlc_deframer
//
// Purpose:
//   Takes the byte stream from a UART receiver and removes HDLC-style
//   framing. 0x7E is the frame flag and 0x7D is the escape byte; the byte
//   after an escape is XORed with 0x20. The last byte of each frame is a
//   checksum: the XOR of every unescaped frame byte, checksum included,
//   must be 0x00.
//
//   Each new unescaped byte is held in a pending register. The previous
//   pending byte is emitted only when the next byte arrives, so the
//   trailing checksum byte is never emitted. Once a frame terminates, the
//   frame status says whether the bytes already emitted are valid.
//
// Ports:
//   i_Clock       system clock, rising edge
//   i_Reset       synchronous active-high reset
//   i_Rx_DV       one-cycle strobe qualifying i_Rx_Byte
//   i_Rx_Byte     received byte
//   o_Data        unescaped payload byte
//   o_Data_DV     one-cycle strobe qualifying o_Data
//   o_Sof         high with o_Data_DV on the first payload byte of a frame
//   o_Frame_Done  one-cycle strobe at frame close, abort or overflow
//   o_Frame_Ok    frame status, meaningful only while o_Frame_Done is high
//   o_Busy        high while inside a frame (DATA or ESC state)
// ---------------------------------------------------------------------------
module uart_hdlc_deframer #(
    parameter int MAX_LEN = 64
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    output logic [7:0] o_Data,
    output logic       o_Data_DV,
    output logic       o_Sof,
    output logic       o_Frame_Done,
    output logic       o_Frame_Ok,
    output logic       o_Busy
);

    localparam int              CW      = $clog2(MAX_LEN + 1);
    localparam logic [CW-1:0]   MAX_CNT = CW'(MAX_LEN);
    localparam logic [7:0]      FLAG    = 8'h7E;
    localparam logic [7:0]      ESCB    = 8'h7D;
    localparam logic [7:0]      ESC_XOR = 8'h20;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        ESC   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [7:0]    xor_q,   xor_d;
    logic [7:0]    pend_q,  pend_d;
    logic [7:0]    data_q,  data_d;
    logic          dv_q,    dv_d;
    logic          sof_q,   sof_d;
    logic          done_q,  done_d;
    logic          ok_q,    ok_d;

    logic          append_en;
    logic [7:0]    append_byte;

    // Saturating byte counter increment: holds at MAX_LEN instead of wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c == MAX_CNT) ? c : c + CW'(1);
    endfunction

    function automatic logic [7:0] unescape(input logic [7:0] b);
        return b ^ ESC_XOR;
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        xor_d       = xor_q;
        pend_d      = pend_q;
        data_d      = data_q;
        dv_d        = 1'b0;
        sof_d       = 1'b0;
        done_d      = 1'b0;
        ok_d        = 1'b0;
        append_en   = 1'b0;
        append_byte = i_Rx_Byte;

        if (i_Rx_DV) begin
            unique case (state_q)
                HUNT: begin
                    if (i_Rx_Byte == FLAG) begin
                        state_d = START;
                        cnt_d   = '0;
                        xor_d   = '0;
                    end
                end
                START: begin
                    // Back-to-back flags are an empty frame: no status pulse.
                    if (i_Rx_Byte == FLAG) begin
                        cnt_d = '0;
                        xor_d = '0;
                    end else if (i_Rx_Byte == ESCB) begin
                        state_d = ESC;
                    end else begin
                        append_en = 1'b1;
                    end
                end
                DATA: begin
                    if (i_Rx_Byte == FLAG) begin
                        // A lone byte is only a checksum with no payload: reject.
                        done_d  = 1'b1;
                        ok_d    = (xor_q == 8'h00) && (cnt_q > CW'(1));
                        state_d = START;
                        cnt_d   = '0;
                        xor_d   = '0;
                    end else if (i_Rx_Byte == ESCB) begin
                        state_d = ESC;
                    end else begin
                        append_en = 1'b1;
                    end
                end
                ESC: begin
                    // Escape followed by flag is an abort; the flag opens the next frame.
                    if (i_Rx_Byte == FLAG) begin
                        done_d  = 1'b1;
                        state_d = START;
                        cnt_d   = '0;
                        xor_d   = '0;
                    end else begin
                        append_en   = 1'b1;
                        append_byte = unescape(i_Rx_Byte);
                    end
                end
                default: state_d = HUNT;
            endcase

            if (append_en) begin
                if (cnt_q == MAX_CNT) begin
                    // Frame too long: fail it and resynchronise on the next flag.
                    done_d  = 1'b1;
                    state_d = HUNT;
                    cnt_d   = '0;
                    xor_d   = '0;
                end else begin
                    // Release the previously held byte; the newest stays pending.
                    if (cnt_q != '0) begin
                        dv_d   = 1'b1;
                        data_d = pend_q;
                        sof_d  = (cnt_q == CW'(1));
                    end
                    pend_d  = append_byte;
                    xor_d   = xor_q ^ append_byte;
                    cnt_d   = sat_inc(cnt_q);
                    state_d = DATA;
                end
            end
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q <= HUNT;
            cnt_q   <= '0;
            xor_q   <= '0;
            pend_q  <= '0;
            data_q  <= '0;
            dv_q    <= 1'b0;
            sof_q   <= 1'b0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            xor_q   <= xor_d;
            pend_q  <= pend_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            sof_q   <= sof_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
        end
    end

    assign o_Data       = data_q;
    assign o_Data_DV    = dv_q;
    assign o_Sof        = sof_q;
    assign o_Frame_Done = done_q;
    assign o_Frame_Ok   = ok_q;
    assign o_Busy       = (state_q == DATA) || (state_q == ESC);

endmodule
